// File: rtl/instr_sequencer_if.sv
// Handshake and control bundle between the instruction sequencer and the core datapath.
// Optional perf-counter ports exist only when SEQ_PERF_CNT_EN is defined.
interface instr_sequencer_if;
  logic        start;
  logic        imem_ack;
  logic        dmem_ack;
  logic        is_ld;
  logic        is_st;
  logic        is_wb;
  logic        is_multi;
  logic        branch_taken;
  logic        imem_req;
  logic        ir_load;
  logic        dmem_req;
  logic        dmem_we;
  logic        rf_we;
  logic        pc_en;
  logic        pc_sel_branch;
  logic        retire;
  logic        busy;
  logic [2:0]  state;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [31:0] stall_cnt;
`endif

  modport slave (
    input  start, imem_ack, dmem_ack, is_ld, is_st, is_wb, is_multi, branch_taken,
    output imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, pc_sel_branch,
    output retire, busy, state
`ifdef SEQ_PERF_CNT_EN
    , output retired_cnt, stall_cnt
`endif
  );

  modport master (
    output start, imem_ack, dmem_ack, is_ld, is_st, is_wb, is_multi, branch_taken,
    input  imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, pc_sel_branch,
    input  retire, busy, state
`ifdef SEQ_PERF_CNT_EN
    , input retired_cnt, stall_cnt
`endif
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; outputs decode the state register and inputs.
// Define SEQ_PERF_CNT_EN to add the retired/stall performance counters.
module instr_sequencer #(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input logic               clk,
  input logic               rst_n,
  instr_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [3:0] EXEC_LAST = 4'(MULDIV_CYCLES - 1);

  state_t     state_r;
  logic [3:0] exec_cnt_r;

  logic   exec_last_s;
  logic   mem_op_s;
  logic   imem_req_s;
  logic   ir_load_s;
  logic   dmem_req_s;
  logic   dmem_we_s;
  logic   rf_we_s;
  logic   retire_s;
  state_t after_retire_s;

  // Output decode and retire detection from current state and decode flags
  always_comb begin
    imem_req_s     = 1'b0;
    ir_load_s      = 1'b0;
    dmem_req_s     = 1'b0;
    dmem_we_s      = 1'b0;
    rf_we_s        = 1'b0;
    retire_s       = 1'b0;
    mem_op_s       = bus.is_ld | bus.is_st;
    exec_last_s    = ~bus.is_multi | (exec_cnt_r == EXEC_LAST);
    after_retire_s = bus.start ? S_FETCH : S_IDLE;
    case (state_r)
      S_FETCH: begin
        imem_req_s = 1'b1;
        ir_load_s  = bus.imem_ack;
      end
      S_EXEC: begin
        retire_s = exec_last_s & ~mem_op_s & ~bus.is_wb;
      end
      S_MEM: begin
        dmem_req_s = 1'b1;
        // Load wins when both load and store flags are raised
        dmem_we_s  = bus.is_st & ~bus.is_ld;
        retire_s   = bus.dmem_ack & ~bus.is_ld;
      end
      S_WB: begin
        rf_we_s  = 1'b1;
        retire_s = 1'b1;
      end
      default: begin
        retire_s = 1'b0;
      end
    endcase
  end

  // Sequencer state machine and EXEC cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      exec_cnt_r <= 4'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          state_r <= bus.start ? S_FETCH : S_IDLE;
        end
        S_FETCH: begin
          state_r <= bus.imem_ack ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          state_r    <= S_EXEC;
          exec_cnt_r <= 4'd0;
        end
        S_EXEC: begin
          if (retire_s) begin
            state_r <= after_retire_s;
          end else if (exec_last_s) begin
            state_r <= mem_op_s ? S_MEM : S_WB;
          end else begin
            exec_cnt_r <= exec_cnt_r + 4'd1;
          end
        end
        S_MEM: begin
          if (retire_s) begin
            state_r <= after_retire_s;
          end else if (bus.dmem_ack) begin
            state_r <= S_WB;
          end else begin
            state_r <= S_MEM;
          end
        end
        S_WB: begin
          state_r <= after_retire_s;
        end
        default: begin
          state_r    <= S_IDLE;
          exec_cnt_r <= 4'd0;
        end
      endcase
    end
  end

  assign bus.imem_req      = imem_req_s;
  assign bus.ir_load       = ir_load_s;
  assign bus.dmem_req      = dmem_req_s;
  assign bus.dmem_we       = dmem_we_s;
  assign bus.rf_we         = rf_we_s;
  assign bus.pc_en         = retire_s;
  assign bus.pc_sel_branch = retire_s & bus.branch_taken;
  assign bus.retire        = retire_s;
  assign bus.busy          = (state_r != S_IDLE);
  assign bus.state         = state_r;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] retired_cnt_r;
  logic [31:0] stall_cnt_r;
  logic        stall_s;

  assign stall_s = ((state_r == S_FETCH) & ~bus.imem_ack) |
                   ((state_r == S_MEM)   & ~bus.dmem_ack);

  // Free-running wrap-around performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt_r <= 32'd0;
      stall_cnt_r   <= 32'd0;
    end else begin
      retired_cnt_r <= retire_s ? retired_cnt_r + 32'd1 : retired_cnt_r;
      stall_cnt_r   <= stall_s  ? stall_cnt_r + 32'd1   : stall_cnt_r;
    end
  end

  assign bus.retired_cnt = retired_cnt_r;
  assign bus.stall_cnt   = stall_cnt_r;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized scoreboard bench for instr_sequencer: per-instruction expectations come from
// stage-count arithmetic and are checked by an independent monitor at each retire pulse.
module tb_instr_sequencer;
  localparam int MULDIV = 4;
  localparam int N_INSTR = 40;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_sequencer_if bus ();

  instr_sequencer #(.MULDIV_CYCLES(MULDIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int lat;
    int imreq;
    int irld;
    int dmreq;
    int dmwe;
    int rfwe;
    int sel;
    int rf_at_ret;
    int nbusy;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   idly = 0;
  int   ddly = 0;
  bit   rsp_en = 1'b0;
  bit   force_ack = 1'b0;
  bit   mon_en = 1'b0;
  int   exp_ret = 0;
  int   exp_stall = 0;

  wire [11:0] outs = {bus.imem_req, bus.ir_load, bus.dmem_req, bus.dmem_we, bus.rf_we,
                      bus.pc_en, bus.pc_sel_branch, bus.retire, bus.busy, bus.state};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  // Memory responder: acks after the configured number of wait cycles, random noise otherwise
  int icnt = 0;
  int dcnt = 0;
  always @(posedge clk) begin
    #1;
    if (!rsp_en) begin
      bus.imem_ack = force_ack;
      bus.dmem_ack = force_ack;
      icnt = 0;
      dcnt = 0;
    end else begin
      if (bus.imem_req) begin
        bus.imem_ack = (icnt == idly);
        icnt++;
      end else begin
        icnt = 0;
        bus.imem_ack = ($urandom_range(0, 3) == 0);
      end
      if (bus.dmem_req) begin
        bus.dmem_ack = (dcnt == ddly);
        dcnt++;
      end else begin
        dcnt = 0;
        bus.dmem_ack = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor: accumulate per-instruction activity, compare against the scoreboard at retire
  int c_lat = 0, c_im = 0, c_ir = 0, c_dm = 0, c_we = 0, c_rf = 0, c_pc = 0;
  bit chk_next = 1'b0;
  int nb = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (chk_next) begin
        chk("next_busy", bus.busy, nb);
        chk_next = 1'b0;
      end
      if (!bus.busy) begin
        chk("idle_outputs", outs, 0);
      end else begin
        c_lat++;
        c_im += bus.imem_req;
        c_ir += bus.ir_load;
        c_dm += bus.dmem_req;
        c_we += bus.dmem_we;
        c_rf += bus.rf_we;
        c_pc += bus.pc_en;
      end
      if (bus.retire) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_retire actual=1 required=0 at %0t", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", c_lat, e.lat);
          chk("imem_req_cycles", c_im, e.imreq);
          chk("ir_load_cycles", c_ir, e.irld);
          chk("dmem_req_cycles", c_dm, e.dmreq);
          chk("dmem_we_cycles", c_we, e.dmwe);
          chk("rf_we_cycles", c_rf, e.rfwe);
          chk("pc_en_cycles", c_pc, 1);
          chk("pc_sel_branch", bus.pc_sel_branch, e.sel);
          chk("rf_we_at_retire", bus.rf_we, e.rf_at_ret);
          nb = e.nbusy;
          chk_next = 1'b1;
        end
        c_lat = 0; c_im = 0; c_ir = 0; c_dm = 0; c_we = 0; c_rf = 0; c_pc = 0;
      end
    end
  end

  initial begin
    bit ld, st, wb, mul, br, mem, wbs, got, stv;
    exp_t e;

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.is_ld = 1'b0;
    bus.is_st = 1'b0;
    bus.is_wb = 1'b0;
    bus.is_multi = 1'b0;
    bus.branch_taken = 1'b0;
    #1;
    chk("reset_state", bus.state, 0);
    chk("reset_outputs", outs, 0);
`ifdef SEQ_PERF_CNT_EN
    chk("reset_retired_cnt", bus.retired_cnt, 0);
    chk("reset_stall_cnt", bus.stall_cnt, 0);
`endif
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    rsp_en = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    idly = $urandom_range(0, 3);
    ddly = $urandom_range(0, 3);
    @(posedge clk);
    #1;

    for (int i = 0; i < N_INSTR; i++) begin
      ld  = ($urandom_range(0, 3) == 0);
      st  = ($urandom_range(0, 3) == 0);
      wb  = $urandom_range(0, 1);
      mul = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 3) == 0);
      mem = ld | st;
      wbs = ld | (~mem & wb);
      e.lat       = (idly + 1) + 1 + (mul ? MULDIV : 1) + (mem ? ddly + 1 : 0) + (wbs ? 1 : 0);
      e.imreq     = idly + 1;
      e.irld      = 1;
      e.dmreq     = mem ? ddly + 1 : 0;
      e.dmwe      = (st & ~ld) ? ddly + 1 : 0;
      e.rfwe      = wbs ? 1 : 0;
      e.sel       = br;
      e.rf_at_ret = wbs;
      bus.is_ld = ld;
      bus.is_st = st;
      bus.is_wb = wb;
      bus.is_multi = mul;
      bus.branch_taken = br;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      stv = (i == N_INSTR - 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
      bus.start = stv;
      e.nbusy = stv;
      sb.push_back(e);
      exp_ret++;
      exp_stall += idly + (mem ? ddly : 0);
      got = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (bus.retire) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        total++;
        bad++;
        $display("FAIL retire_timeout actual=0 required=1 instr=%0d", i);
      end
      idly = $urandom_range(0, 3);
      ddly = $urandom_range(0, 3);
      @(posedge clk);
      #1;
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
`ifdef SEQ_PERF_CNT_EN
    chk("retired_cnt", bus.retired_cnt, exp_ret);
    chk("stall_cnt", bus.stall_cnt, exp_stall);
`endif

    // Reset while a load is stalled in MEM
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    idly = 0;
    ddly = 50;
    bus.is_ld = 1'b1;
    bus.is_st = 1'b0;
    bus.is_wb = 1'b1;
    bus.is_multi = 1'b0;
    bus.branch_taken = 1'b0;
    bus.start = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.dmem_req) begin
        got = 1'b1;
        break;
      end
    end
    chk("mid_mem_reached", got, 1);
    #1;
    bus.start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_mem_reset_state", bus.state, 0);
    chk("mid_mem_reset_outputs", outs, 0);
`ifdef SEQ_PERF_CNT_EN
    chk("mid_mem_reset_retired", bus.retired_cnt, 0);
    chk("mid_mem_reset_stall", bus.stall_cnt, 0);
`endif
    rsp_en = 1'b0;
    force_ack = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("late_ack_state", bus.state, 0);
      chk("late_ack_outputs", outs, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
